// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the pulse_gen stimulus source.
// Holds the wave FSM encoding, default widths and the zero-to-one clamp.
package pulse_gen_pkg;

  localparam int unsigned CNT_W_DEF  = 32;
  localparam int unsigned GATE_W_DEF = 32;
  localparam int unsigned CLAMP_W    = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } wave_st_e;

  // A zero-length phase is meaningless, so it is promoted to one cycle.
  // The 64-bit width covers any CNT_W up to 64.
  function automatic logic [CLAMP_W-1:0] clamp_to_one(input logic [CLAMP_W-1:0] v);
    return (v == '0) ? CLAMP_W'(1) : v;
  endfunction

endpackage

// File: rtl/pulse_gen_gate.sv
// Gate window timer, in-window rising-edge counter and result latch.
// Gate opens one edge after an accepted start and cannot be stalled; a start while busy is dropped.
module pulse_gen_gate
  import pulse_gen_pkg::*;
#(
  parameter int unsigned GATE_W = GATE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [GATE_W-1:0] cfg_gate_i,
  input  logic              start_i,
  input  logic              x_i,
  output logic              gate_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [GATE_W-1:0] x_periods_o
);

  logic              gate_q;
  logic [GATE_W-1:0] gcnt_q;
  logic [GATE_W-1:0] edge_q;
  logic [GATE_W-1:0] edge_d;
  logic              x_prev_q;
  logic              done_q;
  logic [GATE_W-1:0] x_periods_q;
  logic              x_rise;

  assign x_rise = x_i & ~x_prev_q;

  // The edge seen in the final gate cycle still counts, so the close uses edge_d.
  always_comb begin
    edge_d = edge_q;
    if (gate_q && x_rise && (edge_q != {GATE_W{1'b1}})) begin
      edge_d = edge_q + GATE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q      <= 1'b0;
      gcnt_q      <= '0;
      edge_q      <= '0;
      x_prev_q    <= 1'b0;
      done_q      <= 1'b0;
      x_periods_q <= '0;
    end else begin
      x_prev_q <= x_i;
      done_q   <= 1'b0;
      if (gate_q) begin
        edge_q <= edge_d;
        if (gcnt_q == '0) begin
          gate_q      <= 1'b0;
          done_q      <= 1'b1;
          x_periods_q <= edge_d;
        end else begin
          gcnt_q <= gcnt_q - GATE_W'(1);
        end
      end else if (start_i && (cfg_gate_i != '0)) begin
        gate_q <= 1'b1;
        gcnt_q <= cfg_gate_i - GATE_W'(1);
        edge_q <= '0;
      end
    end
  end

  assign gate_o      = gate_q;
  assign busy_o      = gate_q;
  assign done_o      = done_q;
  assign x_periods_o = x_periods_q;

endmodule

// File: rtl/pulse_gen.sv
// Programmable square-wave and gate-window source for frequency meter self-test.
// x follows enable after one edge; no flow control, every strobe is acted on or dropped immediately.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned GATE_W = GATE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_low,
  input  logic [GATE_W-1:0] cfg_gate,
  input  logic              cfg_load,
  input  logic              enable,
  input  logic              start,
  output logic              x,
  output logic              gate,
  output logic              busy,
  output logic              done,
  output logic [GATE_W-1:0] x_periods
);

  wave_st_e         state_q;
  logic             x_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] act_low_q;
  logic [CNT_W-1:0] pend_high_q;
  logic [CNT_W-1:0] pend_low_q;
  logic [CNT_W-1:0] pend_high_d;
  logic [CNT_W-1:0] pend_low_d;

  always_comb begin
    pend_high_d = pend_high_q;
    pend_low_d  = pend_low_q;
    if (cfg_load) begin
      pend_high_d = CNT_W'(clamp_to_one(CLAMP_W'(cfg_high)));
      pend_low_d  = CNT_W'(clamp_to_one(CLAMP_W'(cfg_low)));
    end
  end

  // The active high time is consumed straight into cnt_q when HIGH is entered;
  // only the low time must be held until the HIGH->LOW transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= 1'b0;
      cnt_q       <= '0;
      act_low_q   <= CNT_W'(1);
      pend_high_q <= CNT_W'(1);
      pend_low_q  <= CNT_W'(1);
    end else begin
      pend_high_q <= pend_high_d;
      pend_low_q  <= pend_low_d;
      unique case (state_q)
        ST_IDLE: begin
          x_q <= 1'b0;
          if (enable) begin
            state_q   <= ST_HIGH;
            x_q       <= 1'b1;
            act_low_q <= pend_low_q;
            cnt_q     <= pend_high_q - CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (!enable) begin
            state_q <= ST_IDLE;
            x_q     <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q <= ST_LOW;
            x_q     <= 1'b0;
            cnt_q   <= act_low_q - CNT_W'(1);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_LOW: begin
          if (!enable) begin
            state_q <= ST_IDLE;
            x_q     <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q   <= ST_HIGH;
            x_q       <= 1'b1;
            act_low_q <= pend_low_q;
            cnt_q     <= pend_high_q - CNT_W'(1);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          x_q     <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign x = x_q;

  pulse_gen_gate #(
    .GATE_W(GATE_W)
  ) u_gate (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_gate_i  (cfg_gate),
    .start_i     (start),
    .x_i         (x_q),
    .gate_o      (gate),
    .busy_o      (busy),
    .done_o      (done),
    .x_periods_o (x_periods)
  );

endmodule

// File: tb/tb_pulse_gen.sv
// Bench for pulse_gen: directed scenarios plus random traffic against a period-position model.
module tb_pulse_gen;

  localparam int CNT_W  = 32;
  localparam int GATE_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CNT_W-1:0]  cfg_high;
  logic [CNT_W-1:0]  cfg_low;
  logic [GATE_W-1:0] cfg_gate;
  logic              cfg_load;
  logic              enable;
  logic              start;
  logic              x;
  logic              gate;
  logic              busy;
  logic              done;
  logic [GATE_W-1:0] x_periods;

  int checks   = 0;
  int failures = 0;

  pulse_gen #(.CNT_W(CNT_W), .GATE_W(GATE_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_high(cfg_high), .cfg_low(cfg_low),
    .cfg_gate(cfg_gate), .cfg_load(cfg_load), .enable(enable), .start(start),
    .x(x), .gate(gate), .busy(busy), .done(done), .x_periods(x_periods)
  );

  always #5 clk = ~clk;

  // Model: x is high while the position inside the current period is below the high time.
  bit          m_on, m_x, m_xprev, m_gate, m_done;
  longint      m_pos, m_ah, m_al, m_ph, m_pl;
  longint      m_cyc, m_gs, m_glen, m_rises;
  logic [31:0] m_xp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_on = 0; m_pos = 0; m_ah = 1; m_al = 1; m_ph = 1; m_pl = 1;
      m_x = 0; m_xprev = 0; m_gate = 0; m_done = 0;
      m_cyc = 0; m_gs = 0; m_glen = 0; m_rises = 0; m_xp = '0;
    end else begin
      m_cyc++;
      m_done = 0;
      if (m_gate) begin
        if (m_cyc == m_gs + m_glen) begin
          m_gate = 0; m_done = 1; m_xp = m_rises[31:0];
        end
      end else if (start && cfg_gate != 0) begin
        m_gate = 1; m_gs = m_cyc; m_glen = longint'(cfg_gate); m_rises = 0;
      end
      if (!enable) begin
        m_on = 0;
      end else if (!m_on) begin
        m_on = 1; m_pos = 0; m_ah = m_ph; m_al = m_pl;
      end else begin
        m_pos++;
        if (m_pos == m_ah + m_al) begin
          m_pos = 0; m_ah = m_ph; m_al = m_pl;
        end
      end
      m_xprev = m_x;
      m_x = m_on && (m_pos < m_ah);
      if (m_gate && m_x && !m_xprev) m_rises++;
      if (cfg_load) begin
        m_ph = (cfg_high == 0) ? 1 : longint'(cfg_high);
        m_pl = (cfg_low == 0) ? 1 : longint'(cfg_low);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; cfg_high = '0; cfg_low = '0; cfg_gate = '0;
    cfg_load = 1'b0; enable = 1'b0; start = 1'b0;
    #2;
    checks++;
    if ({x, gate, busy, done} !== 4'b0000 || x_periods !== '0) begin
      failures++;
      $display("FAIL reset_state got x/gate/busy/done=%b%b%b%b xp=%0d want 0000 xp=0", x, gate, busy, done, x_periods);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (x !== 1'b0 || gate !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got x=%b gate=%b want 0 0", x, gate);
    end
  endtask

  task automatic test_wave_3_5();
    bit exp;
    cfg_high = 3; cfg_low = 5; cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0; enable = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      exp = (k % 8) < 3;
      checks++;
      if (x !== exp || x !== m_x) begin
        failures++;
        $display("FAIL wave_3_5 k=%0d got x=%b want %b model %b", k, x, exp, m_x);
      end
    end
  endtask

  task automatic test_cfg_mid_high();
    bit exp, px, found;
    found = 0; px = x;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (x && !px) found = 1;
      px = x;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL cfg_mid_high_rise got no rise want rise within 20 cycles");
    end
    cfg_high = 2; cfg_low = 2; cfg_load = 1'b1;
    for (int k = 1; k < 16; k++) begin
      @(posedge clk); #1;
      cfg_load = 1'b0;
      exp = (k < 3) ? 1'b1 : (k < 8) ? 1'b0 : (((k - 8) % 4) < 2);
      checks++;
      if (x !== exp || x !== m_x) begin
        failures++;
        $display("FAIL cfg_mid_high k=%0d got x=%b want %b model %b", k, x, exp, m_x);
      end
    end
  endtask

  task automatic test_toggle();
    bit px;
    cfg_high = 0; cfg_low = 0; cfg_load = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      cfg_load = 1'b0;
      checks++;
      if (x !== m_x || gate !== m_gate || done !== m_done) begin
        failures++;
        $display("FAIL model_toggle i=%0d got x=%b gate=%b done=%b want %b %b %b", i, x, gate, done, m_x, m_gate, m_done);
      end
    end
    px = x;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (x !== ~px) begin
        failures++;
        $display("FAIL toggle i=%0d got x=%b want %b", i, x, ~px);
      end
      px = x;
    end
  endtask

  task automatic test_enable_off();
    bit exp, px, found;
    cfg_high = 3; cfg_low = 5; cfg_load = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      cfg_load = 1'b0;
    end
    found = 0; px = x;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (x && !px) found = 1;
      px = x;
    end
    @(posedge clk); #1;
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (!found || x !== 1'b0 || m_x !== 1'b0) begin
        failures++;
        $display("FAIL enable_off k=%0d got x=%b rise_found=%b want x=0", k, x, found);
      end
    end
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      exp = k < 3;
      checks++;
      if (x !== exp || x !== m_x) begin
        failures++;
        $display("FAIL reenable k=%0d got x=%b want %b model %b", k, x, exp, m_x);
      end
    end
  endtask

  task automatic test_gate_80();
    int  glen;
    bit  seen;
    glen = 0; seen = 0;
    cfg_gate = 80; start = 1'b1;
    for (int i = 0; i < 120 && !seen; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (x !== m_x || gate !== m_gate || busy !== m_gate || done !== m_done || x_periods !== m_xp) begin
        failures++;
        $display("FAIL model_gate i=%0d got x=%b g=%b b=%b d=%b xp=%0d want %b %b %b %b %0d",
                 i, x, gate, busy, done, x_periods, m_x, m_gate, m_gate, m_done, m_xp);
      end
      if (gate) glen++;
      if (done) seen = 1;
    end
    checks++;
    if (!seen || glen != 80 || x_periods !== 32'd10) begin
      failures++;
      $display("FAIL gate_80 got done_seen=%b len=%0d xp=%0d want 1 80 10", seen, glen, x_periods);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || x_periods !== 32'd10) begin
      failures++;
      $display("FAIL done_pulse got done=%b xp=%0d want 0 10", done, x_periods);
    end
  endtask

  task automatic test_back_to_back();
    int  glen;
    bit  seen;
    glen = 0; seen = 0;
    cfg_gate = 80; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cfg_gate = 5;
    if (gate) glen++;
    for (int i = 0; i < 120 && !seen; i++) begin
      start = (glen == 40 || glen == 80);
      @(posedge clk); #1;
      checks++;
      if (gate !== m_gate || done !== m_done || x_periods !== m_xp) begin
        failures++;
        $display("FAIL model_b2b i=%0d got g=%b d=%b xp=%0d want %b %b %0d", i, gate, done, x_periods, m_gate, m_done, m_xp);
      end
      if (gate) glen++;
      if (done) seen = 1;
    end
    start = 1'b0;
    checks++;
    if (!seen || glen != 80 || x_periods !== 32'd10) begin
      failures++;
      $display("FAIL b2b_window got done_seen=%b len=%0d xp=%0d want 1 80 10", seen, glen, x_periods);
    end
    cfg_gate = 0; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (gate !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL idle_after_close i=%0d got g=%b b=%b d=%b want 0 0 0", i, gate, busy, done);
      end
    end
  endtask

  task automatic test_reset_mid_window();
    cfg_gate = 80; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    checks++;
    if (gate !== 1'b1) begin
      failures++;
      $display("FAIL window_open got gate=%b want 1", gate);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({x, gate, busy, done} !== 4'b0000 || x_periods !== '0) begin
      failures++;
      $display("FAIL async_reset got x/g/b/d=%b%b%b%b xp=%0d want 0000 0", x, gate, busy, done, x_periods);
    end
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || gate !== 1'b0 || x_periods !== '0 || x !== m_x) begin
        failures++;
        $display("FAIL post_reset i=%0d got d=%b g=%b xp=%0d x=%b want 0 0 0 %b", i, done, gate, x_periods, x, m_x);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      cfg_load = 1'b0; start = 1'b0;
      if ($urandom_range(39) == 0) enable = ~enable;
      if ($urandom_range(19) == 0) begin
        cfg_load = 1'b1;
        cfg_high = $urandom_range(6);
        cfg_low  = $urandom_range(6);
      end
      if ($urandom_range(9) == 0) begin
        start    = 1'b1;
        cfg_gate = $urandom_range(30);
      end
      @(posedge clk); #1;
      checks++;
      if (x !== m_x || gate !== m_gate || busy !== m_gate || done !== m_done || x_periods !== m_xp) begin
        failures++;
        $display("FAIL model_random i=%0d got x=%b g=%b b=%b d=%b xp=%0d want %b %b %b %b %0d",
                 i, x, gate, busy, done, x_periods, m_x, m_gate, m_gate, m_done, m_xp);
      end
    end
    cfg_load = 1'b0; start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wave_3_5();
    test_cfg_mid_high();
    test_toggle();
    test_enable_off();
    test_gate_80();
    test_back_to_back();
    test_reset_mid_window();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
